// File: rtl/centrifugacao_rampa.sv
`timescale 1ns/1ps
// centrifugacao_rampa: spin-phase controller. Ramps the motor speed up one level
// every STEP_CYC cycles to a clamped target, holds it for a programmed number of
// cycles, then ramps back down to zero. Supports a graceful stop (iniciar dropped),
// an immediate door-open abort, and one-cycle done/abort status pulses.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   iniciar      spin request; rising edge starts a run, low during ramp-up/hold stops it
//   nivel        target speed level, sampled at start (clamped to MAX_LEVEL)
//   duracao      hold time in cycles, sampled at start (0 treated as 1)
//   porta_aberta door-open interlock, aborts any active run
//   centrifugar  motor enable (SUBIDA/PATAMAR/DESCIDA)
//   velocidade   commanded speed level
//   ocupado      controller is not idle
//   concluido    one-cycle pulse when a run completes
//   abortado     one-cycle pulse when a run is aborted by the door
module centrifugacao_rampa #(
    parameter int unsigned SPEED_W   = 3,
    parameter int unsigned MAX_LEVEL = 5,
    parameter int unsigned STEP_CYC  = 4,
    parameter int unsigned HOLD_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iniciar,
    input  logic [SPEED_W-1:0] nivel,
    input  logic [HOLD_W-1:0]  duracao,
    input  logic               porta_aberta,
    output logic               centrifugar,
    output logic [SPEED_W-1:0] velocidade,
    output logic               ocupado,
    output logic               concluido,
    output logic               abortado
);

    localparam int unsigned STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [SPEED_W-1:0] MAX_LVL   = SPEED_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SUBIDA  = 3'd1,
        PATAMAR = 3'd2,
        DESCIDA = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t             estado, estado_n;
    logic                iniciar_q;
    logic [SPEED_W-1:0]  alvo, alvo_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic [STEP_W-1:0]   step_cnt, step_cnt_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [SPEED_W-1:0]  velocidade_n;
    logic                centrifugar_n, ocupado_n, concluido_n, abortado_n;
    logic                inicio;

    // Start only on a fresh iniciar edge with the door closed.
    assign inicio = iniciar & ~iniciar_q & ~porta_aberta;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= IDLE;
            iniciar_q   <= 1'b0;
            alvo        <= '0;
            hold        <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            velocidade  <= '0;
            centrifugar <= 1'b0;
            ocupado     <= 1'b0;
            concluido   <= 1'b0;
            abortado    <= 1'b0;
        end else begin
            estado      <= estado_n;
            iniciar_q   <= iniciar;
            alvo        <= alvo_n;
            hold        <= hold_n;
            step_cnt    <= step_cnt_n;
            hold_cnt    <= hold_cnt_n;
            velocidade  <= velocidade_n;
            centrifugar <= centrifugar_n;
            ocupado     <= ocupado_n;
            concluido   <= concluido_n;
            abortado    <= abortado_n;
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        estado_n      = estado;
        alvo_n        = alvo;
        hold_n        = hold;
        step_cnt_n    = step_cnt;
        hold_cnt_n    = hold_cnt;
        velocidade_n  = velocidade;
        abortado_n    = 1'b0;

        case (estado)
            IDLE: begin
                velocidade_n = '0;
                if (inicio) begin
                    alvo_n     = (nivel > MAX_LVL) ? MAX_LVL : nivel;
                    hold_n     = (duracao == '0) ? HOLD_W'(1) : duracao;
                    step_cnt_n = '0;
                    hold_cnt_n = '0;
                    estado_n   = (alvo_n == '0) ? FIM : SUBIDA;
                end
            end
            SUBIDA: begin
                if (!iniciar) begin
                    // Stop before the first level is reached has nothing to ramp down.
                    step_cnt_n = '0;
                    estado_n   = (velocidade == '0) ? FIM : DESCIDA;
                end else if (step_cnt == STEP_LAST) begin
                    step_cnt_n   = '0;
                    velocidade_n = velocidade + SPEED_W'(1);
                    if (velocidade_n == alvo) begin
                        hold_cnt_n = '0;
                        estado_n   = PATAMAR;
                    end
                end else begin
                    step_cnt_n = step_cnt + STEP_W'(1);
                end
            end
            PATAMAR: begin
                if (!iniciar || hold_cnt == hold - HOLD_W'(1)) begin
                    step_cnt_n = '0;
                    estado_n   = DESCIDA;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            DESCIDA: begin
                if (velocidade == '0) begin
                    estado_n = FIM;
                end else if (step_cnt == STEP_LAST) begin
                    step_cnt_n   = '0;
                    velocidade_n = velocidade - SPEED_W'(1);
                    if (velocidade_n == '0) begin
                        estado_n = FIM;
                    end
                end else begin
                    step_cnt_n = step_cnt + STEP_W'(1);
                end
            end
            FIM: begin
                estado_n = IDLE;
            end
            default: begin
                estado_n     = IDLE;
                velocidade_n = '0;
            end
        endcase

        // Door interlock overrides every other transition.
        if (estado != IDLE && porta_aberta) begin
            estado_n     = IDLE;
            velocidade_n = '0;
            abortado_n   = 1'b1;
        end

        centrifugar_n = (estado_n == SUBIDA) || (estado_n == PATAMAR) || (estado_n == DESCIDA);
        ocupado_n     = (estado_n != IDLE);
        concluido_n   = (estado_n == FIM);
    end

endmodule

// File: tb/tb_centrifugacao_rampa.sv
`timescale 1ns/1ps
// Bench for centrifugacao_rampa: stimulus queues timestamped expected output
// changes; a monitor compares every observed output change against the queue.
module tb_centrifugacao_rampa;

    localparam int unsigned SPEED_W = 3;
    localparam int unsigned HOLD_W  = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               iniciar;
    logic [SPEED_W-1:0] nivel;
    logic [HOLD_W-1:0]  duracao;
    logic               porta_aberta;
    logic               centrifugar;
    logic [SPEED_W-1:0] velocidade;
    logic               ocupado;
    logic               concluido;
    logic               abortado;

    centrifugacao_rampa #(
        .SPEED_W(3), .MAX_LEVEL(5), .STEP_CYC(4), .HOLD_W(8)
    ) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar), .nivel(nivel), .duracao(duracao),
        .porta_aberta(porta_aberta), .centrifugar(centrifugar), .velocidade(velocidade),
        .ocupado(ocupado), .concluido(concluido), .abortado(abortado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output vector layout: {centrifugar, velocidade[2:0], ocupado, concluido, abortado}
    typedef struct {
        int         cyc;
        logic [6:0] v;
    } ev_t;

    ev_t        q[$];
    ev_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev;
    logic [6:0] cur;

    task automatic push(input int c, input bit cent, input int vel, input bit oc,
                        input bit co, input bit ab);
        ev_t e;
        e.cyc = c;
        e.v   = {cent, 3'(vel), oc, co, ab};
        q.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int lvl, input int dur);
        nivel   = 3'(lvl);
        duracao = 8'(dur);
        iniciar = 1'b1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Monitor: every change of the output vector must match the next queued event.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {centrifugar, velocidade, ocupado, concluido, abortado};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d got=%b required no change", cyc, cur);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.v !== cur) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d val=%b required cyc=%0d val=%b",
                                 cyc, cur, mon_e.cyc, mon_e.v);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int c;
        rst          = 1'b1;
        iniciar      = 1'b0;
        nivel        = '0;
        duracao      = '0;
        porta_aberta = 1'b0;

        // Reset held 3 cycles with random inputs.
        repeat (3) begin
            iniciar      = 1'($urandom_range(1, 0));
            nivel        = 3'($urandom);
            duracao      = 8'($urandom);
            porta_aberta = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        chk("rst_centrifugar", int'(centrifugar), 0);
        chk("rst_velocidade",  int'(velocidade),  0);
        chk("rst_ocupado",     int'(ocupado),     0);
        chk("rst_concluido",   int'(concluido),   0);
        chk("rst_abortado",    int'(abortado),    0);
        rst = 1'b0; iniciar = 1'b0; nivel = '0; duracao = '0; porta_aberta = 1'b0;
        prev   = 7'b0;
        mon_en = 1'b1;
        wait_until(cyc + 3);

        // Normal run nivel=3 duracao=10; iniciar stays high past FIM (no restart).
        c = cyc;
        push(c+1,  1, 0, 1, 0, 0);
        push(c+5,  1, 1, 1, 0, 0);
        push(c+9,  1, 2, 1, 0, 0);
        push(c+13, 1, 3, 1, 0, 0);
        push(c+27, 1, 2, 1, 0, 0);
        push(c+31, 1, 1, 1, 0, 0);
        push(c+35, 0, 0, 1, 1, 0);
        push(c+36, 0, 0, 0, 0, 0);
        start(3, 10);
        wait_until(c+45);
        iniciar = 1'b0;
        wait_until(c+48);

        // Clamp: nivel=7 peaks at 5, duracao=1.
        c = cyc;
        push(c+1, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) push(c+1+4*k, 1, k, 1, 0, 0);
        for (int k = 4; k >= 1; k--) push(c+42-4*k, 1, k, 1, 0, 0);
        push(c+42, 0, 0, 1, 1, 0);
        push(c+43, 0, 0, 0, 0, 0);
        start(7, 1);
        wait_until(c+44);
        iniciar = 1'b0;
        wait_until(c+47);

        // Door opens mid-hold at level 3.
        c = cyc;
        push(c+1,  1, 0, 1, 0, 0);
        push(c+5,  1, 1, 1, 0, 0);
        push(c+9,  1, 2, 1, 0, 0);
        push(c+13, 1, 3, 1, 0, 0);
        push(c+17, 0, 0, 0, 0, 1);
        push(c+18, 0, 0, 0, 0, 0);
        start(3, 20);
        wait_until(c+16);
        porta_aberta = 1'b1;
        wait_until(c+17);
        porta_aberta = 1'b0;
        iniciar      = 1'b0;
        wait_until(c+22);

        // Stop during ramp-up at level 2.
        c = cyc;
        push(c+1,  1, 0, 1, 0, 0);
        push(c+5,  1, 1, 1, 0, 0);
        push(c+9,  1, 2, 1, 0, 0);
        push(c+15, 1, 1, 1, 0, 0);
        push(c+19, 0, 0, 1, 1, 0);
        push(c+20, 0, 0, 0, 0, 0);
        start(5, 5);
        wait_until(c+10);
        iniciar = 1'b0;
        wait_until(c+24);

        // nivel=0 goes straight to FIM without enabling the motor.
        c = cyc;
        push(c+1, 0, 0, 1, 1, 0);
        push(c+2, 0, 0, 0, 0, 0);
        start(0, 3);
        wait_until(c+3);
        iniciar = 1'b0;
        wait_until(c+6);

        // Reset during ramp-down.
        c = cyc;
        push(c+1,  1, 0, 1, 0, 0);
        push(c+5,  1, 1, 1, 0, 0);
        push(c+9,  1, 2, 1, 0, 0);
        push(c+14, 1, 1, 1, 0, 0);
        push(c+16, 0, 0, 0, 0, 0);
        start(2, 1);
        wait_until(c+15);
        rst = 1'b1;
        wait_until(c+16);
        rst     = 1'b0;
        iniciar = 1'b0;
        wait_until(c+22);

        mon_en = 1'b0;
        while (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing required cyc=%0d val=%b", mon_e.cyc, mon_e.v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
